// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] PC_RESET     = 32'h0040_0000;
   localparam logic [31:0] PC_INCREMENT = 32'h0000_0004;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage control, instruction ROM and IF/ID pipeline register signals.
interface fetch_stage_if;

   logic        stall_in;
   logic        flush_in;
   logic        branch_taken_in;
   logic [31:0] branch_target_in;
   logic        jump_in;
   logic [31:0] jump_target_in;
   logic [31:0] imem_addr_out;
   logic [31:0] imem_data_in;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic [31:0] instr_out;
   logic        valid_out;
   logic [31:0] fetch_count_out;

   modport slave (
      input  stall_in, flush_in, branch_taken_in, branch_target_in,
             jump_in, jump_target_in, imem_data_in,
      output imem_addr_out, pc_out, pc_plus4_out, instr_out, valid_out,
             fetch_count_out
   );

   modport master (
      output stall_in, flush_in, branch_taken_in, branch_target_in,
             jump_in, jump_target_in, imem_data_in,
      input  imem_addr_out, pc_out, pc_plus4_out, instr_out, valid_out,
             fetch_count_out
   );

endinterface

// File: rtl/fetch_stage_next_pc_select.sv
// Combinational next-PC priority mux: jump > branch > stall > sequential.
module next_pc_select #(
   parameter logic [31:0] PC_INCREMENT = 32'h0000_0004
) (
   input  logic [31:0] pc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic [31:0] next_pc,
   output logic        redirect
);

   // Targets are word aligned regardless of what the producer computed.
   always_comb begin
      next_pc = pc + PC_INCREMENT;
      if (jump)        next_pc = {jump_target[31:2], 2'b00};
      else if (branch) next_pc = {branch_target[31:2], 2'b00};
      else if (stall)  next_pc = pc;
   end

   assign redirect = jump | branch;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencing and IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET     = fetch_stage_pkg::PC_RESET,
   parameter logic [31:0] PC_INCREMENT = fetch_stage_pkg::PC_INCREMENT
) (
   input  logic         clock,
   input  logic         reset,
   fetch_stage_if.slave bus
);

   state_t      state, state_nxt;
   logic [31:0] pc, next_pc;
   logic        redirect;
   logic        upd_pc, bubble, load;

   logic [31:0] pc_q, pc_plus4_q, instr_q, count_q;
   logic        valid_q;

   next_pc_select #(.PC_INCREMENT(PC_INCREMENT)) u_sel (
      .pc           (pc),
      .jump         (bus.jump_in),
      .jump_target  (bus.jump_target_in),
      .branch       (bus.branch_taken_in),
      .branch_target(bus.branch_target_in),
      .stall        (bus.stall_in),
      .next_pc      (next_pc),
      .redirect     (redirect)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= BOOT;
      else        state <= state_nxt;
   end

   // BOOT only primes the ROM with PC; ROM data is meaningful from RUN on.
   always_comb begin
      state_nxt          = state;
      upd_pc             = 1'b0;
      bubble             = 1'b1;
      load               = 1'b0;
      bus.imem_addr_out  = pc;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            upd_pc            = 1'b1;
            bus.imem_addr_out = next_pc;
            bubble            = redirect | bus.flush_in;
            load              = !bubble && !bus.stall_in;
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc         <= PC_RESET;
         pc_q       <= PC_RESET;
         pc_plus4_q <= PC_RESET + PC_INCREMENT;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         if (upd_pc) pc <= next_pc;
         if (bubble) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
         end else if (load) begin
            pc_q       <= pc;
            pc_plus4_q <= pc + PC_INCREMENT;
            instr_q    <= bus.imem_data_in;
            valid_q    <= 1'b1;
            count_q    <= count_q + 32'd1;
         end
      end
   end

   assign bus.pc_out          = pc_q;
   assign bus.pc_plus4_out    = pc_plus4_q;
   assign bus.instr_out       = instr_q;
   assign bus.valid_out       = valid_q;
   assign bus.fetch_count_out = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

   localparam logic [31:0] PCR = 32'h0040_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   fetch_stage_if bus ();

   fetch_stage #(.PC_RESET(PCR), .PC_INCREMENT(32'h4)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h2008_0001;
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   always @(posedge clock) bus.imem_data_in <= rom(bus.imem_addr_out);

   // Reference model of the architectural fetch behaviour
   logic [31:0] m_pc, m_pco, m_p4, m_instr, m_cnt;
   logic        m_vld, m_boot;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = PCR; m_pco = PCR; m_p4 = PCR + 32'd4;
      m_instr = 32'h0; m_cnt = 32'h0; m_vld = 1'b0; m_boot = 1'b1;
   endtask

   function automatic logic [31:0] m_next_pc();
      if (bus.jump_in)         return bus.jump_target_in & 32'hFFFF_FFFC;
      if (bus.branch_taken_in) return bus.branch_target_in & 32'hFFFF_FFFC;
      if (bus.stall_in)        return m_pc;
      return m_pc + 32'd4;
   endfunction

   task automatic chk_regs(input string tag);
      chk({tag, ".valid"}, {31'b0, bus.valid_out}, {31'b0, m_vld});
      chk({tag, ".instr"}, bus.instr_out, m_instr);
      chk({tag, ".pc"}, bus.pc_out, m_pco);
      chk({tag, ".pc4"}, bus.pc_plus4_out, m_p4);
      chk({tag, ".cnt"}, bus.fetch_count_out, m_cnt);
   endtask

   task automatic drive(input logic j, input logic [31:0] jt, input logic b,
                        input logic [31:0] bt, input logic s, input logic f);
      bus.jump_in = j; bus.jump_target_in = jt;
      bus.branch_taken_in = b; bus.branch_target_in = bt;
      bus.stall_in = s; bus.flush_in = f;
   endtask

   // Checks the fetch address for the current inputs, then one clock edge.
   task automatic step(input string tag);
      logic [31:0] npc;
      #1;
      npc = m_boot ? m_pc : m_next_pc();
      chk({tag, ".addr"}, bus.imem_addr_out, npc);
      if (m_boot) begin
         m_boot = 1'b0; m_vld = 1'b0; m_instr = 32'h0;
      end else begin
         if (bus.jump_in || bus.branch_taken_in || bus.flush_in) begin
            m_vld = 1'b0; m_instr = 32'h0;
         end else if (!bus.stall_in) begin
            m_pco = m_pc; m_p4 = m_pc + 32'd4; m_instr = rom(m_pc);
            m_vld = 1'b1; m_cnt = m_cnt + 32'd1;
         end
         m_pc = npc;
      end
      @(posedge clock);
      #1;
      chk_regs(tag);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk_regs("rst");
      chk("rst.addr", bus.imem_addr_out, PCR);
      @(posedge clock); #1;
      reset = 1'b1;

      step("boot");
      step("first");
      chk("first.pc_c", bus.pc_out, 32'h0040_0000);
      chk("first.instr_c", bus.instr_out, 32'h2008_0001);
      chk("first.cnt_c", bus.fetch_count_out, 32'd1);
      step("seq1");
      chk("seq1.pc_c", bus.pc_out, 32'h0040_0004);
      step("seq2");
      chk("seq2.pc_c", bus.pc_out, 32'h0040_0008);

      drive(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         chk("stall.pc_c", bus.pc_out, 32'h0040_0008);
         chk("stall.cnt_c", bus.fetch_count_out, 32'd3);
         chk("stall.addr_c", bus.imem_addr_out, 32'h0040_000C);
      end
      drive(0, 0, 0, 0, 0, 0);
      step("resume");
      chk("resume.pc_c", bus.pc_out, 32'h0040_000C);
      chk("resume.cnt_c", bus.fetch_count_out, 32'd4);

      drive(1, 32'h0040_0100, 1, 32'h0040_0200, 1, 0);
      step("redir");
      chk("redir.valid_c", {31'b0, bus.valid_out}, 32'd0);
      chk("redir.instr_c", bus.instr_out, 32'h0);
      drive(0, 0, 0, 0, 0, 0);
      step("tgt");
      chk("tgt.pc_c", bus.pc_out, 32'h0040_0100);

      drive(0, 0, 0, 0, 1, 1);
      step("flush");
      chk("flush.valid_c", {31'b0, bus.valid_out}, 32'd0);
      chk("flush.addr_c", bus.imem_addr_out, 32'h0040_0104);
      drive(0, 0, 0, 0, 0, 0);
      step("postflush");
      chk("postflush.pc_c", bus.pc_out, 32'h0040_0104);

      drive(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
      step("wrapj");
      drive(0, 0, 0, 0, 0, 0);
      step("wrap0");
      chk("wrap0.pc_c", bus.pc_out, 32'hFFFF_FFFC);
      chk("wrap0.pc4_c", bus.pc_plus4_out, 32'h0);
      step("wrap1");
      chk("wrap1.pc_c", bus.pc_out, 32'h0);

      for (int i = 0; i < 300; i++) begin
         drive(($urandom % 10) == 0, $urandom, ($urandom % 8) == 0, $urandom,
               ($urandom % 4) == 0, ($urandom % 10) == 0);
         step("rnd");
      end

      drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 0);
      @(posedge clock); #3;
      reset = 1'b0;
      #1;
      model_reset();
      chk_regs("async");
      chk("async.addr", bus.imem_addr_out, PCR);
      @(posedge clock); #1;
      chk_regs("inrst");
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      step("reboot");
      step("refirst");
      chk("refirst.pc_c", bus.pc_out, 32'h0040_0000);
      chk("refirst.instr_c", bus.instr_out, 32'h2008_0001);
      chk("refirst.cnt_c", bus.fetch_count_out, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
